// File: rtl/alu_pkg.sv
// Shared ALU definitions: result-mux select codes and the MOD sequencer FSM states.
package alu_pkg;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_XOR = 3'b010;
  localparam logic [2:0] SEL_NOR = 3'b011;
  localparam logic [2:0] SEL_SLT = 3'b100;
  localparam logic [2:0] SEL_ADD = 3'b101;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_MOD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mod_state_e;

endpackage

// File: rtl/mod_step.sv
// One restoring-remainder step: shift in a dividend bit, subtract the divisor unless it borrows.
module mod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   r_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             unused_r_msb;

  // The MSB of R is always 0 between steps because R < b, so only the low bits shift up.
  assign unused_r_msb = r[WIDTH];
  assign shifted      = {r[WIDTH-1:0], a_bit};
  assign diff         = {1'b0, shifted} - {2'b00, b};
  assign borrow       = diff[WIDTH+1];
  assign r_next       = borrow ? shifted : diff[WIDTH:0];

endmodule

// File: rtl/alu_mod_sequencer.sv
// Multi-cycle unsigned op_a mod op_b engine with a start/busy/done handshake,
// one restoring step per clock, MSB of the dividend first.
module alu_mod_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] remainder
);

  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  mod_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r, r_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             accept;
  logic             b_zero;

  assign b_zero = (op_b == '0);
  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  mod_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .a_bit  (a_q[cnt]),
    .b      (b_q),
    .r_next (r_nxt)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = b_zero ? DONE : RUN;
      RUN:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = start ? (b_zero ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      r           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      a_q <= op_a;
      b_q <= op_b;
      cnt <= CW'(WIDTH - 1);
      r   <= '0;
      // A zero divisor skips RUN entirely and reports the dividend unchanged.
      if (b_zero) begin
        remainder   <= op_a;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      r   <= r_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        remainder   <= r_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mod_sequencer.sv
// Directed self-checking bench for alu_mod_sequencer (WIDTH = 32).
module tb_alu_mod_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] remainder;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mod_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .remainder   (remainder)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it to its done pulse. Latency counts edges after the accept edge.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rem, input logic exp_dbz,
                        input int exp_lat, input int exp_busy);
    int lat;
    int busy_cyc;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = ~a;
    op_b  = '0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      tick();
      lat++;
    end
    n_cmp++;
    if (lat !== exp_lat || done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s latency: got %0d (done=%b), expected %0d", name, lat, done, exp_lat);
    end
    n_cmp++;
    if (busy_cyc !== exp_busy) begin
      n_bad++;
      $display("FAIL %s busy cycles: got %0d, expected %0d", name, busy_cyc, exp_busy);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy with done: got %b, expected 0", name, busy);
    end
    n_cmp++;
    if (remainder !== exp_rem) begin
      n_bad++;
      $display("FAIL %s remainder: got %h, expected %h", name, remainder, exp_rem);
    end
    n_cmp++;
    if (div_by_zero !== exp_dbz) begin
      n_bad++;
      $display("FAIL %s div_by_zero: got %b, expected %b", name, div_by_zero, exp_dbz);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || remainder !== exp_rem) begin
      n_bad++;
      $display("FAIL %s after done: done=%b rem=%h, expected done=0 rem=%h",
               name, done, remainder, exp_rem);
    end
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({busy, done, div_by_zero, remainder} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset outputs: busy=%b done=%b dbz=%b rem=%h, expected all 0",
               busy, done, div_by_zero, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset idle: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    run_op("basic_17_mod_5", 32'd17, 32'd5, 32'd2, 1'b0, 32, 32);
  endtask

  task automatic test_wide_divisor;
    run_op("wide_msb_div", 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32, 32);
    run_op("wide_all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 32, 32);
  endtask

  task automatic test_div_zero;
    run_op("div_zero", 32'h1234, 32'h0, 32'h1234, 1'b1, 0, 0);
  endtask

  task automatic test_ignored_start;
    int n_done;
    int done_lat;
    op_a  = 32'd3;
    op_b  = 32'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    done_lat = -1;
    for (int lat = 0; lat < 46; lat++) begin
      if (done) begin
        n_done++;
        if (done_lat < 0) done_lat = lat;
      end
      if (lat == 9) begin
        start = 1'b1;
        op_a  = 32'd100;
        op_b  = 32'd7;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if (n_done !== 1 || done_lat !== 32) begin
      n_bad++;
      $display("FAIL ignored_start pulses: got %0d at %0d, expected 1 at 32", n_done, done_lat);
    end
    n_cmp++;
    if (remainder !== 32'd3) begin
      n_bad++;
      $display("FAIL ignored_start remainder: got %h, expected %h", remainder, 32'd3);
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    op_a  = 32'd100;
    op_b  = 32'd7;
    start = 1'b1;
    tick();
    gap = 0;
    while (!done && gap < 40) begin
      tick();
      gap++;
    end
    n_cmp++;
    if (gap !== 32 || remainder !== 32'd2) begin
      n_bad++;
      $display("FAIL b2b first: latency %0d rem=%h, expected 32 rem=%h", gap, remainder, 32'd2);
    end
    op_a = 32'd0;
    op_b = 32'd9;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b reaccept: busy=%b done=%b, expected 1 0", busy, done);
    end
    gap = 1;
    while (!done && gap < 45) begin
      tick();
      gap++;
    end
    n_cmp++;
    if (gap !== 33 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b second: gap %0d rem=%h dbz=%b, expected 33 rem=0 dbz=0",
               gap, remainder, div_by_zero);
    end
    start = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b end: done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid;
    int n_done;
    run_op("preload_dbz", 32'hABCD, 32'h0, 32'hABCD, 1'b1, 0, 0);
    op_a  = 32'd17;
    op_b  = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, div_by_zero, remainder} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_mid outputs: busy=%b done=%b dbz=%b rem=%h, expected all 0",
               busy, done, div_by_zero, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin
      n_bad++;
      $display("FAIL reset_mid activity: got %0d busy/done cycles, expected 0", n_done);
    end
    run_op("after_reset_50_mod_6", 32'd50, 32'd6, 32'd2, 1'b0, 32, 32);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide_divisor();
    test_div_zero();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
